l2_ctrl_sequencer: RTL and testbench

Synthesizable controller that shares the unified L2 tag/state array between three requesters: L1 instruction port, L1 data port and the snoop port. It arbitrates one request at a time and sequences lookup, optional victim eviction, line fill, and MESI/LRU update. It then returns a response and keeps hit/read/write statistics. It sits between the L1 miss interfaces/bus snooper and the L2 array datapath.

---
 rtl/l2_ctrl_pkg.sv | 46 ++++
 rtl/l2_req_arbiter.sv | 57 +++++
 rtl/l2_ctrl_sequencer.sv | 178 +++++++++++++++++
 tb/tb_l2_ctrl_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_ctrl_pkg.sv
// Shared types for the L2 control sequencer: command codes, snoop
// encodings, FSM states and requester IDs.
package l2_ctrl_pkg;

    typedef enum logic [3:0] {
        CMD_DR   = 4'd0,
        CMD_DW   = 4'd1,
        CMD_IR   = 4'd2,
        CMD_SINV = 4'd3,
        CMD_SR   = 4'd4,
        CMD_SW   = 4'd5,
        CMD_RFO  = 4'd6
    } cmd_e;

    localparam logic [1:0] SNP_INV = 2'd0;
    localparam logic [1:0] SNP_RD  = 2'd1;
    localparam logic [1:0] SNP_WR  = 2'd2;
    localparam logic [1:0] SNP_RFO = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_EVICT,
        S_FILL,
        S_UPDATE,
        S_RESP
    } state_e;

    localparam logic [1:0] SRC_L1I = 2'd0;
    localparam logic [1:0] SRC_L1D = 2'd1;
    localparam logic [1:0] SRC_SNP = 2'd2;

    function automatic logic [3:0] snp_to_cmd(input logic [1:0] c);
        logic [3:0] r;
        r = CMD_SINV;
        unique case (c)
            SNP_INV: r = CMD_SINV;
            SNP_RD:  r = CMD_SR;
            SNP_WR:  r = CMD_SW;
            SNP_RFO: r = CMD_RFO;
            default: r = CMD_SINV;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/l2_req_arbiter.sv
// Picks one requester per IDLE cycle: snoop first unless it has starved
// L1 for STARVE_MAX grants; L1I/L1D share by round-robin.
module l2_req_arbiter
    import l2_ctrl_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       idle,
    input  logic       i_req,
    input  logic       d_req,
    input  logic       s_req,
    input  logic       accept,
    output logic [2:0] grant
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [SW-1:0] streak;
    logic          ptr_d;
    logic          l1_win;
    logic          pick_d;

    always_comb begin
        l1_win = (i_req | d_req) && (!s_req || streak == SMAX);
        pick_d = d_req && (ptr_d || !i_req);
        grant  = 3'b000;
        if (idle) begin
            if (l1_win) begin
                grant[SRC_L1D] = pick_d;
                grant[SRC_L1I] = !pick_d;
            end else if (s_req) begin
                grant[SRC_SNP] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
            ptr_d  <= 1'b1;
        end else if (idle) begin
            if (accept && grant[SRC_SNP]) begin
                if (streak != SMAX)
                    streak <= streak + 1'b1;
            end else if (accept || !s_req) begin
                streak <= '0;
            end
            // next L1 turn goes to the port that was not just served
            if (accept && !grant[SRC_SNP])
                ptr_d <= grant[SRC_L1I];
        end
    end

endmodule

// File: rtl/l2_ctrl_sequencer.sv
// Sequences one L2 request at a time through lookup, evict, fill and
// MESI/LRU update, then responds and updates hit/read/write statistics.
module l2_ctrl_sequencer
    import l2_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l1i_valid,
    output logic              l1i_ready,
    input  logic [ADDR_W-1:0] l1i_addr,
    input  logic              l1d_valid,
    output logic              l1d_ready,
    input  logic              l1d_write,
    input  logic [ADDR_W-1:0] l1d_addr,
    input  logic              snp_valid,
    output logic              snp_ready,
    input  logic [1:0]        snp_cmd,
    input  logic [ADDR_W-1:0] snp_addr,
    output logic              lk_valid,
    output logic [3:0]        lk_cmd,
    output logic [ADDR_W-1:0] lk_addr,
    input  logic              lk_done,
    input  logic              lk_hit,
    input  logic              lk_victim,
    output logic              ev_valid,
    input  logic              ev_done,
    output logic              fill_valid,
    input  logic              fill_done,
    output logic              upd_valid,
    output logic              resp_valid,
    output logic [1:0]        resp_src,
    output logic              resp_hit,
    input  logic              stat_clear,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic              busy
);

    state_e            state;
    logic [2:0]        grant;
    logic              idle;
    logic              accept;
    logic [1:0]        src_n;
    logic [3:0]        cmd_n;
    logic [ADDR_W-1:0] addr_n;
    logic              is_rd;

    assign idle      = (state == S_IDLE);
    assign accept    = |grant;
    assign l1i_ready = grant[SRC_L1I];
    assign l1d_ready = grant[SRC_L1D];
    assign snp_ready = grant[SRC_SNP];
    assign busy      = !idle;
    assign is_rd     = (lk_cmd == CMD_DR) || (lk_cmd == CMD_IR);

    l2_req_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .idle   (idle),
        .i_req  (l1i_valid),
        .d_req  (l1d_valid),
        .s_req  (snp_valid),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        src_n  = SRC_L1D;
        cmd_n  = CMD_DR;
        addr_n = l1d_addr;
        unique case (1'b1)
            grant[SRC_L1I]: begin
                src_n  = SRC_L1I;
                cmd_n  = CMD_IR;
                addr_n = l1i_addr;
            end
            grant[SRC_L1D]: begin
                src_n  = SRC_L1D;
                cmd_n  = l1d_write ? CMD_DW : CMD_DR;
                addr_n = l1d_addr;
            end
            grant[SRC_SNP]: begin
                src_n  = SRC_SNP;
                cmd_n  = snp_to_cmd(snp_cmd);
                addr_n = snp_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lk_valid   <= 1'b0;
            lk_cmd     <= CMD_DR;
            lk_addr    <= '0;
            ev_valid   <= 1'b0;
            fill_valid <= 1'b0;
            upd_valid  <= 1'b0;
            resp_valid <= 1'b0;
            resp_src   <= SRC_L1I;
            resp_hit   <= 1'b0;
        end else begin
            upd_valid  <= 1'b0;
            resp_valid <= 1'b0;
            unique case (state)
                S_IDLE: if (accept) begin
                    lk_cmd   <= cmd_n;
                    lk_addr  <= addr_n;
                    resp_src <= src_n;
                    lk_valid <= 1'b1;
                    state    <= S_LOOKUP;
                end
                S_LOOKUP: if (lk_done) begin
                    lk_valid <= 1'b0;
                    resp_hit <= lk_hit;
                    if (lk_hit) begin
                        upd_valid <= 1'b1;
                        state     <= S_UPDATE;
                    end else if (resp_src == SRC_SNP) begin
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else if (lk_victim) begin
                        ev_valid <= 1'b1;
                        state    <= S_EVICT;
                    end else begin
                        fill_valid <= 1'b1;
                        state      <= S_FILL;
                    end
                end
                S_EVICT: if (ev_done) begin
                    ev_valid   <= 1'b0;
                    fill_valid <= 1'b1;
                    state      <= S_FILL;
                end
                S_FILL: if (fill_done) begin
                    fill_valid <= 1'b0;
                    upd_valid  <= 1'b1;
                    state      <= S_UPDATE;
                end
                S_UPDATE: begin
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // snoop commands never match DR/IR/DW, so only L1 traffic is counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
        end else if (stat_clear) begin
            hit_cnt <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
        end else if (state == S_RESP) begin
            if (is_rd && rd_cnt != '1)
                rd_cnt <= rd_cnt + 1'b1;
            if (is_rd && resp_hit && hit_cnt != '1)
                hit_cnt <= hit_cnt + 1'b1;
            if (lk_cmd == CMD_DW && wr_cnt != '1)
                wr_cnt <= wr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_l2_ctrl_sequencer.sv
// Scoreboard bench for l2_ctrl_sequencer with a behavioural array model.
// Stimulus pushes expected responses; a monitor pops them on resp_valid.
module tb_l2_ctrl_sequencer;
    import l2_ctrl_pkg::*;

    localparam logic [31:0] I_A = 32'h0000_2080;
    localparam logic [31:0] D_A = 32'h0000_1040;
    localparam logic [31:0] S_A = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        l1i_valid, l1i_ready;
    logic [31:0] l1i_addr;
    logic        l1d_valid, l1d_ready, l1d_write;
    logic [31:0] l1d_addr;
    logic        snp_valid, snp_ready;
    logic [1:0]  snp_cmd;
    logic [31:0] snp_addr;
    logic        lk_valid;
    logic [3:0]  lk_cmd;
    logic [31:0] lk_addr;
    logic        lk_done, lk_hit, lk_victim;
    logic        ev_valid, ev_done, fill_valid, fill_done;
    logic        upd_valid, resp_valid, resp_hit, busy;
    logic [1:0]  resp_src;
    logic        stat_clear;
    logic [31:0] hit_cnt, rd_cnt, wr_cnt;

    always #5 clk = ~clk;

    l2_ctrl_sequencer #(
        .ADDR_W     (32),
        .STARVE_MAX (4),
        .CNT_W      (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .l1i_valid  (l1i_valid),
        .l1i_ready  (l1i_ready),
        .l1i_addr   (l1i_addr),
        .l1d_valid  (l1d_valid),
        .l1d_ready  (l1d_ready),
        .l1d_write  (l1d_write),
        .l1d_addr   (l1d_addr),
        .snp_valid  (snp_valid),
        .snp_ready  (snp_ready),
        .snp_cmd    (snp_cmd),
        .snp_addr   (snp_addr),
        .lk_valid   (lk_valid),
        .lk_cmd     (lk_cmd),
        .lk_addr    (lk_addr),
        .lk_done    (lk_done),
        .lk_hit     (lk_hit),
        .lk_victim  (lk_victim),
        .ev_valid   (ev_valid),
        .ev_done    (ev_done),
        .fill_valid (fill_valid),
        .fill_done  (fill_done),
        .upd_valid  (upd_valid),
        .resp_valid (resp_valid),
        .resp_src   (resp_src),
        .resp_hit   (resp_hit),
        .stat_clear (stat_clear),
        .hit_cnt    (hit_cnt),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt),
        .busy       (busy)
    );

    typedef struct {
        logic [1:0]  src;
        logic        hit;
        logic [3:0]  cmd;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   upd_n = 0;
    int   upd_cyc = -1, resp_cyc = -1, ev_cyc = -1, fill_cyc = -1;
    logic ev_prev = 1'b0, fill_prev = 1'b0;
    logic cfg_hit = 1'b0, cfg_victim = 1'b0;
    int   lk_lat = 0, ev_lat = 0, fill_lat = 0;
    int   lk_n = 0, ev_n = 0, fill_n = 0;
    logic clr_on_resp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] s, input logic h,
                            input logic [3:0] c, input logic [31:0] a);
        exp_t e;
        e.src = s; e.hit = h; e.cmd = c; e.addr = a;
        exp_q.push_back(e);
    endtask

    // array model: done pulses after a programmable number of cycles
    initial begin
        lk_done = 0; ev_done = 0; fill_done = 0;
        lk_hit = 0; lk_victim = 0;
        forever begin
            @(negedge clk);
            lk_done = 0; ev_done = 0; fill_done = 0;
            if (lk_valid) begin
                if (lk_n == lk_lat) begin
                    lk_done = 1; lk_hit = cfg_hit; lk_victim = cfg_victim;
                end
                lk_n++;
            end else lk_n = 0;
            if (ev_valid) begin
                if (ev_n == ev_lat) ev_done = 1;
                ev_n++;
            end else ev_n = 0;
            if (fill_valid) begin
                if (fill_n == fill_lat) fill_done = 1;
                fill_n++;
            end else fill_n = 0;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (upd_valid) begin upd_n++; upd_cyc = cyc; end
            if (ev_valid && !ev_prev) ev_cyc = cyc;
            if (fill_valid && !fill_prev) fill_cyc = cyc;
            ev_prev = ev_valid;
            fill_prev = fill_valid;
            if (resp_valid) begin
                resp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_src), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_src", 32'(resp_src), 32'(e.src));
                    chk("resp_hit", 32'(resp_hit), 32'(e.hit));
                    chk("lk_cmd", 32'(lk_cmd), 32'(e.cmd));
                    chk("lk_addr", lk_addr, e.addr);
                end
            end
        end
    end

    initial begin
        stat_clear = 0;
        forever begin
            @(negedge clk);
            #1;
            if (resp_valid && clr_on_resp) begin
                stat_clear = 1;
                clr_on_resp = 0;
                @(posedge clk);
                #1 stat_clear = 0;
            end
        end
    end

    task automatic drive_until(input int ni, input int nd, input int ns,
                               input logic dwr, input logic [1:0] scmd);
        int ci = 0, cd = 0, cs = 0, g = 0;
        @(negedge clk);
        l1i_valid = (ni > 0);
        l1d_valid = (nd > 0);
        snp_valid = (ns > 0);
        l1d_write = dwr;
        snp_cmd   = scmd;
        while ((ci < ni || cd < nd || cs < ns) && g < 400) begin
            #1;
            if (l1i_valid && l1i_ready) begin ci++; acc_q.push_back(cyc); end
            if (l1d_valid && l1d_ready) begin cd++; acc_q.push_back(cyc); end
            if (snp_valid && snp_ready) begin cs++; acc_q.push_back(cyc); end
            @(negedge clk);
            if (ci >= ni) l1i_valid = 0;
            if (cd >= nd) l1d_valid = 0;
            if (cs >= ns) snp_valid = 0;
            g++;
        end
        l1i_valid = 0; l1d_valid = 0; snp_valid = 0;
        if (g >= 400) chk("accept_timeout", 32'(ci + cd + cs), 32'(ni + nd + ns));
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin
            @(negedge clk);
            #1;
            g++;
        end while ((exp_q.size() != 0 || busy) && g < 200);
        if (g >= 200) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic clear_stats();
        @(negedge clk);
        stat_clear = 1;
        @(negedge clk);
        stat_clear = 0;
    endtask

    initial begin
        int u0, g;
        rst_n = 0;
        l1i_valid = 0; l1d_valid = 0; snp_valid = 0;
        l1d_write = 0; snp_cmd = SNP_RD;
        l1i_addr = I_A; l1d_addr = D_A; snp_addr = S_A;
        repeat (3) @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_lk_valid", 32'(lk_valid), 0);
        chk("rst_ready", 32'({l1i_ready, l1d_ready, snp_ready}), 0);
        chk("rst_cnt", rd_cnt | hit_cnt | wr_cnt, 0);

        // L1D read hit, minimum latency
        cfg_hit = 1; cfg_victim = 0; lk_lat = 0;
        acc_q.delete();
        push_exp(SRC_L1D, 1, CMD_DR, D_A);
        drive_until(0, 1, 0, 0, SNP_RD);
        wait_idle();
        chk("upd_latency", 32'(upd_cyc - acc_q[0]), 2);
        chk("resp_latency", 32'(resp_cyc - acc_q[0]), 3);
        chk("t1_rd_cnt", rd_cnt, 1);
        chk("t1_hit_cnt", hit_cnt, 1);

        // L1I read miss with victim: evict then fill
        clear_stats();
        cfg_hit = 0; cfg_victim = 1; ev_lat = 2; fill_lat = 4;
        ev_cyc = -1; fill_cyc = -1; u0 = upd_n;
        push_exp(SRC_L1I, 0, CMD_IR, I_A);
        drive_until(1, 0, 0, 0, SNP_RD);
        wait_idle();
        chk("ev_seen", 32'(ev_cyc >= 0), 1);
        chk("ev_to_fill", 32'(fill_cyc - ev_cyc), 3);
        chk("t2_upd_once", 32'(upd_n - u0), 1);
        chk("t2_rd_cnt", rd_cnt, 1);
        chk("t2_hit_cnt", hit_cnt, 0);

        // snoop RFO miss: no update, counters untouched
        cfg_hit = 0; cfg_victim = 0; u0 = upd_n;
        push_exp(SRC_SNP, 0, CMD_RFO, S_A);
        drive_until(0, 0, 1, 0, SNP_RFO);
        wait_idle();
        chk("t3_no_upd", 32'(upd_n - u0), 0);
        chk("t3_rd_cnt", rd_cnt, 1);
        chk("t3_hit_cnt", hit_cnt, 0);

        // L1D write hit counts as write, not hit
        cfg_hit = 1;
        push_exp(SRC_L1D, 1, CMD_DW, D_A);
        drive_until(0, 1, 0, 1, SNP_RD);
        wait_idle();
        chk("t4_wr_cnt", wr_cnt, 1);
        chk("t4_hit_cnt", hit_cnt, 0);

        // snoop streak limit: S S S S D S S
        for (int i = 0; i < 4; i++) push_exp(SRC_SNP, 1, CMD_SR, S_A);
        push_exp(SRC_L1D, 1, CMD_DR, D_A);
        for (int i = 0; i < 2; i++) push_exp(SRC_SNP, 1, CMD_SR, S_A);
        drive_until(0, 1, 6, 0, SNP_RD);
        wait_idle();
        chk("t5_rd_cnt", rd_cnt, 2);
        chk("t5_hit_cnt", hit_cnt, 1);

        // round-robin from reset: D I D I
        do_reset();
        #1;
        chk("rr_rst_cnt", rd_cnt | hit_cnt | wr_cnt, 0);
        acc_q.delete();
        push_exp(SRC_L1D, 1, CMD_DR, D_A);
        push_exp(SRC_L1I, 1, CMD_IR, I_A);
        push_exp(SRC_L1D, 1, CMD_DR, D_A);
        push_exp(SRC_L1I, 1, CMD_IR, I_A);
        drive_until(2, 2, 0, 0, SNP_RD);
        wait_idle();
        chk("rr_accepts", 32'(acc_q.size()), 4);
        if (acc_q.size() >= 2)
            chk("accept_spacing", 32'(acc_q[1] - acc_q[0]), 4);
        chk("t6_rd_cnt", rd_cnt, 4);
        chk("t6_hit_cnt", hit_cnt, 4);

        // reset in FILL drops the request
        cfg_hit = 0; cfg_victim = 0; fill_lat = 50;
        drive_until(0, 1, 0, 0, SNP_RD);
        g = 0;
        while (!fill_valid && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk("fill_reached", 32'(fill_valid), 1);
        rst_n = 0;
        #1;
        chk("rst_fill_valid", 32'(fill_valid), 0);
        chk("rst_busy_fill", 32'(busy), 0);
        chk("rst_cnt_fill", rd_cnt | hit_cnt | wr_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        cfg_hit = 1; fill_lat = 4;
        push_exp(SRC_L1D, 1, CMD_DR, D_A);
        drive_until(0, 1, 0, 0, SNP_RD);
        wait_idle();
        chk("post_rst_hit_cnt", hit_cnt, 1);

        // stat_clear during a hit RESP wins
        clr_on_resp = 1;
        push_exp(SRC_L1I, 1, CMD_IR, I_A);
        drive_until(1, 0, 0, 0, SNP_RD);
        wait_idle();
        chk("clr_hit_cnt", hit_cnt, 0);
        chk("clr_rd_cnt", rd_cnt, 0);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
